// File: rtl/uop_pkg.sv
// Shared types and sizing helpers for the micro-op queue.
// The micro-op word layout and the default queue geometry live here.
package uop_pkg;

  localparam int UOP_WIDTH       = 64;
  localparam int UOP_QUEUE_DEPTH = 8;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [1:0]  fu;
    logic [35:0] imm;
  } uop_t;

  // Pointer width for a power-of-two entry count; never narrower than 1 bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count width must also represent the full value DEPTH.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uop_queue_mem.sv
// Storage array for uop_queue: one write port, one asynchronous read port.
// Contents are zeroed by the synchronous active-low reset so the head word is never X.
module uop_queue_mem
  import uop_pkg::*;
#(
  parameter int DEPTH = UOP_QUEUE_DEPTH,
  parameter int UOP_W = UOP_WIDTH,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [PW-1:0]    waddr_i,
  input  logic [UOP_W-1:0] wdata_i,
  input  logic [PW-1:0]    raddr_i,
  output logic [UOP_W-1:0] rdata_o
);

  logic [UOP_W-1:0] mem_q [DEPTH];

  // NOTE: the array is cleared on reset on purpose: uop_out is visible while
  // the queue is empty and must read 0, not X, after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uop_queue.sv
// Micro-op FIFO between decode and issue using the valid/stalled handshake.
// Optional perf ports (occupancy, high_water) are built when UOP_QUEUE_OCC_EN is defined.
module uop_queue
  import uop_pkg::*;
#(
  parameter int DEPTH = UOP_QUEUE_DEPTH,
  parameter int UOP_W = UOP_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          enabled,
  input  logic                          prev_valid,
  input  logic [UOP_W-1:0]              uop_in,
  output logic                          stalled,
  output logic                          valid,
  output logic [UOP_W-1:0]              uop_out,
  input  logic                          next_stalled
`ifdef UOP_QUEUE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
  output logic [$clog2(DEPTH+1)-1:0]    high_water
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uop_queue: DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          push, pop;

  // Both handshake outputs decode registered count only, so next_stalled
  // never reaches stalled combinationally.
  assign stalled = (count_q == CW'(DEPTH));
  assign valid   = (count_q != '0);

  // clear wins over both sides: a same-cycle push is discarded, not written.
  assign push = enabled & prev_valid   & ~stalled & ~clear;
  assign pop  = enabled & valid        & ~next_stalled & ~clear;

  // NOTE: every signal assigned here gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  uop_queue_mem #(
    .DEPTH (DEPTH),
    .UOP_W (UOP_W),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (uop_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (uop_out)
  );

`ifdef UOP_QUEUE_OCC_EN
  logic [CW-1:0] high_water_q, high_water_d;

  // Track the post-update count so high_water moves in step with occupancy.
  always_comb begin
    high_water_d = high_water_q;
    if (clear) begin
      high_water_d = '0;
    end else if (count_d > high_water_q) begin
      high_water_d = count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      high_water_q <= '0;
    end else begin
      high_water_q <= high_water_d;
    end
  end

  assign occupancy  = count_q;
  assign high_water = high_water_q;
`endif

endmodule
